// File: rtl/eth_tx_pkg.sv
// rtl/eth_tx_pkg.sv - shared types and constants for the RMII transmit FCS path
//
// Contents:
//   state_e          frame sequencer states (IDLE, DATA, PAD, FCS, GAP)
//   CRC32_POLY_REFL  reflected CRC-32 polynomial
//   CRC32_INIT       CRC register preset value
//   FCS_DIBITS       number of dibits in the appended 32-bit FCS
package eth_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PAD,
    FCS,
    GAP
  } state_e;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam int          FCS_DIBITS      = 16;

endpackage

// File: rtl/crc32_dibit.sv
// rtl/crc32_dibit.sv - combinational CRC-32 advance by one dibit
//
// Ports:
//   crc_in   [31:0] current CRC register value
//   dibit    [1:0]  input dibit, bit 0 is shifted in first
//   crc_out  [31:0] CRC value after both bits
module crc32_dibit
  import eth_tx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [1:0]  dibit,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  // LSB-first (reflected) shift: wire order matches bit order.
  always_comb begin
    c = crc_in;
    for (int i = 0; i < 2; i++) begin
      c = (c >> 1) ^ (((c[0] ^ dibit[i]) == 1'b1) ? CRC32_POLY_REFL : 32'h0);
    end
    crc_out = c;
  end

endmodule

// File: rtl/fcs_append.sv
// rtl/fcs_append.sv - RMII TX dibit forwarder that appends CRC-32 FCS and inter-frame gap
//
// Build option: FCS_APPEND_PAD_EN - zero-pad short frames to MIN_DIBITS before the FCS.
//
// Ports:
//   clk    in   dibit clock
//   rst    in   synchronous reset, active low
//   axiiv  in   input dibit valid (one high run per frame)
//   axiid  in   [1:0] input dibit, bit 0 first on the wire
//   axiir  out  ready; low from end of frame through the gap
//   axiov  out  output dibit valid
//   axiod  out  [1:0] output dibit (data, optional pad, FCS)
//   done   out  pulse with the last FCS dibit
//   drop   out  pulse for each dibit offered while not ready
module fcs_append
  import eth_tx_pkg::*;
#(
  parameter int IFG_DIBITS = 48
`ifdef FCS_APPEND_PAD_EN
  , parameter int MIN_DIBITS = 240
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  output logic       axiir,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       done,
  output logic       drop
);

  localparam int GAP_W = (IFG_DIBITS > 1) ? $clog2(IFG_DIBITS) : 1;

  state_e           state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [3:0]       fcs_idx_q, fcs_idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             axiov_q, axiov_d;
  logic [1:0]       axiod_q, axiod_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;

  logic [1:0]  crc_din;
  logic [31:0] crc_next;
  logic [31:0] fcs;
  logic [1:0]  fcs_dibit;
  logic        pad_needed;
  logic        tail;

  // Ready drops combinationally on the first idle cycle of a frame so the
  // FCS can follow the last data dibit without a bubble.
  assign axiir = (state_q == IDLE) || (state_q == DATA && axiiv);

  assign fcs       = ~crc_q;
  assign fcs_dibit = fcs[{fcs_idx_q, 1'b0} +: 2];

`ifdef FCS_APPEND_PAD_EN
  assign pad_needed = int'(cnt_q) < MIN_DIBITS;
  assign crc_din    = (state_q == PAD || (state_q == DATA && !axiiv)) ? 2'b00 : axiid;
`else
  assign pad_needed = 1'b0;
  assign crc_din    = axiid;
`endif

  crc32_dibit u_crc (
    .crc_in  (crc_q),
    .dibit   (crc_din),
    .crc_out (crc_next)
  );

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    fcs_idx_d = fcs_idx_q;
    gap_d     = gap_q;
    axiov_d   = 1'b0;
    axiod_d   = 2'b00;
    done_d    = 1'b0;
    drop_d    = axiiv && !axiir;
    tail      = 1'b0;

    case (state_q)
      IDLE: begin
        if (axiiv) begin
          crc_d   = crc_next;
          axiov_d = 1'b1;
          axiod_d = axiid;
          cnt_d   = 8'd1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (axiiv) begin
          crc_d   = crc_next;
          axiov_d = 1'b1;
          axiod_d = axiid;
          cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end else begin
          tail = 1'b1;
        end
      end
      PAD: tail = 1'b1;
      FCS: begin
        axiov_d   = 1'b1;
        axiod_d   = fcs_dibit;
        fcs_idx_d = fcs_idx_q + 4'd1;
        if (fcs_idx_q == 4'(FCS_DIBITS - 1)) begin
          done_d  = 1'b1;
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(IFG_DIBITS - 1)) begin
          crc_d   = CRC32_INIT;
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Post-data tail: either one more zero pad dibit (folded into the CRC)
    // or the first FCS dibit, taken from the CRC before any further update.
    if (tail) begin
      axiov_d = 1'b1;
      if (pad_needed) begin
        crc_d   = crc_next;
        axiod_d = 2'b00;
        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        state_d = PAD;
      end else begin
        axiod_d   = fcs[1:0];
        fcs_idx_d = 4'd1;
        state_d   = FCS;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      crc_q     <= CRC32_INIT;
      cnt_q     <= '0;
      fcs_idx_q <= '0;
      gap_q     <= '0;
      axiov_q   <= 1'b0;
      axiod_q   <= 2'b00;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      fcs_idx_q <= fcs_idx_d;
      gap_q     <= gap_d;
      axiov_q   <= axiov_d;
      axiod_q   <= axiod_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  assign axiov = axiov_q;
  assign axiod = axiod_q;
  assign done  = done_q;
  assign drop  = drop_q;

endmodule

// File: tb/tb_fcs_append.sv
// tb/tb_fcs_append.sv - scoreboard bench for fcs_append
module tb_fcs_append;

  localparam int IFG = 48;
  localparam int MIN = 240;
`ifdef FCS_APPEND_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       axiiv = 1'b0;
  logic [1:0] axiid = 2'b00;
  logic       axiir, axiov, done, drop;
  logic [1:0] axiod;

  fcs_append dut (
    .clk   (clk),
    .rst   (rst),
    .axiiv (axiiv),
    .axiid (axiid),
    .axiir (axiir),
    .axiov (axiov),
    .axiod (axiod),
    .done  (done),
    .drop  (drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] d;
    logic       done;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [1:0]  fr[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          drop_cnt = 0;
  int          done_cyc = 0;
  int          cyc = 0;
  int          waits_g = 0;
  bit          use_ref_fcs = 1'b0;
  logic [31:0] ref_fcs = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
    return (c >> 1) ^ (((c[0] ^ b) == 1'b1) ? 32'hEDB88320 : 32'h0);
  endfunction

  function automatic int pad_len(input int n);
    return (PAD_ON && n < MIN) ? MIN - n : 0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (axiov) begin
      if (sb.size() == 0) begin
        check("extra_out", 32'(axiov), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("axiod", 32'(axiod), 32'(mon_e.d));
        check("done", 32'(done), 32'(mon_e.done));
      end
    end else begin
      if (done) check("done_no_valid", 32'(done), 32'd0);
      if (axiod != 2'b00) check("axiod_idle", 32'(axiod), 32'd0);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (drop) drop_cnt++;
  end

  task automatic rand_frame(input int n);
    fr.delete();
    for (int i = 0; i < n; i++) fr.push_back(2'($urandom_range(0, 3)));
  endtask

  // Drives fr[0..n-1]; the first dibit is held until accepted.
  task automatic drive_frame(input int n, input bit tail);
    logic [31:0] c;
    logic [31:0] f;
    waits_g = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      axiiv = 1'b1;
      axiid = fr[i];
      @(negedge clk);
      if (i == 0) begin
        while (!axiir && waits_g < 600) begin
          waits_g++;
          @(negedge clk);
        end
        if (!axiir) begin
          check("accept_timeout", 32'(axiir), 32'd1);
          axiiv = 1'b0;
          return;
        end
      end else begin
        check("axiir_data", 32'(axiir), 32'd1);
      end
      sb.push_back({fr[i], 1'b0});
    end
    if (tail) begin
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) c = crc_bit(crc_bit(c, fr[i][0]), fr[i][1]);
      for (int p = 0; p < pad_len(n); p++) begin
        c = crc_bit(crc_bit(c, 1'b0), 1'b0);
        sb.push_back({2'b00, 1'b0});
      end
      f = use_ref_fcs ? ref_fcs : ~c;
      for (int k = 0; k < 16; k++) sb.push_back({f[2*k +: 2], (k == 15)});
    end
  endtask

  task automatic finish_frame(input int n);
    int run;
    int d0;
    run = 0;
    d0 = done_cnt;
    @(posedge clk); #1;
    axiiv = 1'b0;
    axiid = 2'b00;
    @(negedge clk);
    while (!axiir && run < 1000) begin
      run++;
      @(negedge clk);
    end
    check("axiir_low_run", run, pad_len(n) + 16 + IFG);
    check("done_count", done_cnt, d0 + 1);
    check("gap_len", cyc - done_cyc, IFG);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    byte   b;
    int    d0;
    int    wait_b;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_axiov", 32'(axiov), 32'd0);
    check("rst_axiod", 32'(axiod), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_axiir", 32'(axiir), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // "123456789": known CRC-32 check value when unpadded.
    s = "123456789";
    fr.delete();
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      for (int j = 0; j < 4; j++) fr.push_back(b[2*j +: 2]);
    end
    use_ref_fcs = !PAD_ON;
    ref_fcs = 32'hCBF43926;
    drive_frame(36, 1'b1);
    finish_frame(36);
    use_ref_fcs = 1'b0;

    // Next frame offered during FCS; held until the first ready cycle.
    d0 = drop_cnt;
    rand_frame(20);
    drive_frame(20, 1'b1);
    @(posedge clk); #1;
    axiiv = 1'b0;
    rand_frame(37);
    drive_frame(37, 1'b1);
    wait_b = waits_g;
    finish_frame(37);
    check("accept_wait", wait_b, pad_len(20) + 63);
    check("drop_count", drop_cnt - d0, pad_len(20) + 63);

    // Reset at dibit 10 aborts the frame.
    rand_frame(14);
    drive_frame(10, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    axiiv = 1'b1;
    axiid = fr[10];
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    axiiv = 1'b0;
    axiid = 2'b00;
    @(negedge clk);
    check("abort_axiov", 32'(axiov), 32'd0);
    check("abort_axiir", 32'(axiir), 32'd1);
    check("abort_sb", sb.size(), 0);
    repeat (30) @(negedge clk);
    rand_frame(24);
    drive_frame(24, 1'b1);
    finish_frame(24);

    // Single-dibit frame.
    fr.delete();
    fr.push_back(2'b11);
    drive_frame(1, 1'b1);
    finish_frame(1);

    // Long frame past the counter saturation point.
    rand_frame(300);
    drive_frame(300, 1'b1);
    finish_frame(300);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fcs_append.md
Name: fcs_append

Overview:
- RMII transmit-side frame check sequence (FCS) generator.
- Accepts an outgoing Ethernet frame (preamble/SFD already stripped, no FCS) as a 2-bit dibit stream and forwards it with 1-cycle latency.
- Immediately after the last data dibit, appends the 32-bit CRC32 FCS as 16 dibits, then enforces an inter-frame gap before accepting the next frame.
- Sits between the TX frame builder and the RMII preamble/line driver.

Parameters:
- IFG_DIBITS, 48, number of idle output cycles after the FCS (96 bit times).
- MIN_DIBITS, 240, minimum payload length in dibits (60 bytes), used only with the optional feature.

Ports:
- clk    input   1  system clock, one dibit per cycle.
- rst    input   1  synchronous reset, active-low: asserted when 0, sampled on the rising edge of clk.
- axiiv  input   1  input dibit valid; a high run delimits one frame.
- axiid  input   2  input dibit; bit 0 is the earlier bit on the wire.
- axiir  output  1  ready; upstream must hold axiiv low while this is 0.
- axiov  output  1  output dibit valid.
- axiod  output  2  output dibit (data, then FCS).
- done   output  1  one-cycle pulse, coincident with the last FCS dibit on the output.
- drop   output  1  one-cycle pulse when axiiv=1 is sampled while axiir=0.

Behaviour:
- Reset (rst=0 at the clock edge):
  - State goes to IDLE; CRC register loads 32'hFFFFFFFF.
  - axiov=0, axiod=0, done=0, drop=0, axiir=1.
  - All counters are cleared.
  - Reset mid-frame aborts the frame: no FCS is emitted and nothing is held over.
- CRC definition: reflected polynomial 32'hEDB88320, init 32'hFFFFFFFF.
  - Each dibit updates the CRC with axiid[0] first, then axiid[1].
  - FCS = ~crc.
  - FCS dibit k (k = 0..15) = FCS[2k+1:2k], so the low byte goes first, LSB first.
- States:
  - IDLE:
    - axiir=1, axiov=0.
    - axiiv=1: CRC is updated with the dibit, the dibit is registered to the output, and the state moves to DATA.
  - DATA:
    - axiir=1.
    - Each cycle with axiiv=1: the CRC is updated, axiov=1 and axiod=axiid on the next cycle, and the dibit counter increments (8-bit, saturating at 255).
    - First cycle with axiiv=0 (falling edge): state moves to FCS (or PAD, see Optional Feature) and axiir drops to 0 in the same cycle.
  - FCS:
    - axiir=0.
    - The 16 FCS dibits are emitted on consecutive cycles.
    - The first FCS dibit appears on the cycle directly after the last data dibit; there is no bubble.
    - done pulses with dibit 15.
    - Then the state moves to GAP.
  - GAP:
    - axiir=0, axiov=0, axiod=0 for IFG_DIBITS cycles.
    - Then CRC is set to 32'hFFFFFFFF and the state returns to IDLE.
- Latency: output is exactly 1 cycle behind input for data dibits.
- Total output length = N_data + 16 dibits.
- Boundary conditions:
  - A single-dibit frame is legal and gets a normal FCS.
  - A frame length that is not a multiple of 4 dibits is not checked; the FCS is appended after the last dibit regardless.
  - axiiv=1 while axiir=0: the dibit is ignored (no CRC update, no output), drop pulses, and the state is unaffected.
  - axiiv=1 in the final GAP cycle: drop pulses.
  - axiiv=1 in the first IDLE cycle: the dibit is accepted.
- Counter saturation at 255 only matters for the PAD comparison; frames longer than 255 dibits are unaffected.

Optional Feature:
- Macro FCS_APPEND_PAD_EN.
- Defined:
  - A PAD state sits between DATA and FCS.
  - If the dibit counter < MIN_DIBITS, zero dibits are emitted contiguously and included in the CRC until the count reaches MIN_DIBITS, then the state moves to FCS.
  - axiir=0 during PAD.
  - Frames already at or above MIN_DIBITS go straight to FCS.
- Undefined: no PAD state; short frames are sent unpadded.

Decomposition:
- Package eth_tx_pkg contains:
  - state enum {IDLE, DATA, PAD, FCS, GAP}.
  - CRC32_POLY_REFL = 32'hEDB88320, CRC32_INIT = 32'hFFFFFFFF.
  - FCS_DIBITS = 16.
- One sub-module, crc32_dibit: a combinational next-CRC function of (crc_in[31:0], dibit[1:0]). It is instantiated once; the top owns the CRC register.

Test Plan:
- ASCII "123456789" (36 dibits, back-to-back), PAD_EN off:
  - Output is 36 data dibits at 1-cycle latency, then FCS = 32'hCBF43926.
  - First FCS dibits are 2'b10, 2'b01, 2'b10, 2'b00 (0x26), then 2'b01, 2'b10, 2'b11, 2'b00 (0x39).
  - done pulses on output cycle 52; axiir=0 for 16+48 cycles.
- Same frame with PAD_EN on:
  - 36 data dibits + 204 zero dibits + 16 FCS dibits.
  - FCS matches a reference model of CRC32 over the 9 bytes plus 51 zero bytes.
- Second frame offered during the FCS phase:
  - drop pulses each offered cycle; output is unchanged.
  - A frame presented on the first cycle axiir=1 is accepted and gets a correct FCS.
- rst=0 for 1 cycle at dibit 10 of a frame:
  - Next cycle axiov=0 and axiir=1; no FCS is emitted.
  - A following frame's FCS is correct, proving the CRC was reinitialised.
- Single-dibit frame axiid=2'b11:
  - Output is 2'b11, then 16 FCS dibits matching the reference model.
  - done pulses; the gap is exactly 48 cycles.
